// File: rtl/frame_tx_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : frame_tx_scheduler
//  Description : Burst scheduler for a frame transmitter. Accepts a burst
//                request (frame length, frame count, inter-frame guard),
//                then for each frame checks that the TX FIFO holds a whole
//                frame, waits for the transmitter, launches it with a
//                one-cycle start_tx pulse, tracks busy/done handshaking
//                and inserts the guard gap. It reports the burst result in
//                status and raises a sticky irq.
//  Ports       : clk, reset (async, active-high)
//                start_req, abort, irq_ack      - host controls
//                frame_len, frame_count,
//                guard_interval                 - burst parameters
//                size_fifo_tx, ready_tx         - transmitter side inputs
//                start_tx                       - per-frame launch pulse
//                busy, frames_sent, status, irq - burst progress / result
//  Revision    : 1.0  initial release
// ============================================================================
module frame_tx_scheduler (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_req,
    input  logic        abort,
    input  logic [7:0]  frame_len,
    input  logic [7:0]  frame_count,
    input  logic [31:0] guard_interval,
    input  logic [7:0]  size_fifo_tx,
    input  logic        ready_tx,
    input  logic        irq_ack,
    output logic        start_tx,
    output logic        busy,
    output logic [7:0]  frames_sent,
    output logic [1:0]  status,
    output logic        irq
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_CHECK      = 3'd1,
        S_WAIT_READY = 3'd2,
        S_LAUNCH     = 3'd3,
        S_WAIT_BUSY  = 3'd4,
        S_WAIT_DONE  = 3'd5,
        S_GUARD      = 3'd6
    } state_t;

    localparam logic [1:0] c_ST_OK       = 2'd0;
    localparam logic [1:0] c_ST_UNDERRUN = 2'd1;
    localparam logic [1:0] c_ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] c_ST_ABORTED  = 2'd3;

    state_t      r_state, w_state_next;
    logic [7:0]  r_len, r_count, r_sent, r_tmo;
    logic [31:0] r_guard, r_guard_cnt;
    logic [1:0]  r_status, w_status_next;
    logic        r_irq;

    logic        w_accept, w_finish, w_inc_sent, w_load_guard, w_dec_guard;
    logic        w_clr_tmo, w_inc_tmo, w_start_tx;
    logic [7:0]  w_sent_inc;

    // Saturating increment: the completed-frame count never wraps.
    assign w_sent_inc = (r_sent == 8'hFF) ? 8'hFF : r_sent + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_status_next = r_status;
        w_accept      = 1'b0;
        w_finish      = 1'b0;
        w_inc_sent    = 1'b0;
        w_load_guard  = 1'b0;
        w_dec_guard   = 1'b0;
        w_clr_tmo     = 1'b0;
        w_inc_tmo     = 1'b0;
        w_start_tx    = 1'b0;
        // Abort outranks everything, including the launch pulse itself.
        if (r_state != S_IDLE && abort) begin
            w_state_next  = S_IDLE;
            w_finish      = 1'b1;
            w_status_next = c_ST_ABORTED;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_req) begin
                        w_accept     = 1'b1;
                        w_state_next = S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (size_fifo_tx >= r_len && r_len != 8'd0) begin
                        w_state_next = S_WAIT_READY;
                    end else begin
                        w_finish      = 1'b1;
                        w_status_next = c_ST_UNDERRUN;
                        w_state_next  = S_IDLE;
                    end
                end
                S_WAIT_READY: begin
                    if (ready_tx) w_state_next = S_LAUNCH;
                end
                S_LAUNCH: begin
                    w_start_tx   = 1'b1;
                    w_clr_tmo    = 1'b1;
                    w_state_next = S_WAIT_BUSY;
                end
                S_WAIT_BUSY: begin
                    if (!ready_tx) begin
                        w_state_next = S_WAIT_DONE;
                    end else begin
                        w_inc_tmo = 1'b1;
                        // Counter is about to reach 255 with the transmitter
                        // still idle: it never picked up the frame.
                        if (r_tmo == 8'd254) begin
                            w_finish      = 1'b1;
                            w_status_next = c_ST_TIMEOUT;
                            w_state_next  = S_IDLE;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (ready_tx) begin
                        w_inc_sent = 1'b1;
                        if (w_sent_inc == r_count) begin
                            w_finish      = 1'b1;
                            w_status_next = c_ST_OK;
                            w_state_next  = S_IDLE;
                        end else if (r_guard == 32'd0) begin
                            w_state_next = S_CHECK;
                        end else begin
                            w_load_guard = 1'b1;
                            w_state_next = S_GUARD;
                        end
                    end
                end
                S_GUARD: begin
                    // Loaded with the guard value on entry, so leaving when it
                    // reads 1 spends exactly guard_interval cycles here.
                    if (r_guard_cnt <= 32'd1) w_state_next = S_CHECK;
                    else                      w_dec_guard  = 1'b1;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_len       <= 8'd0;
            r_count     <= 8'd0;
            r_guard     <= 32'd0;
            r_guard_cnt <= 32'd0;
            r_tmo       <= 8'd0;
            r_sent      <= 8'd0;
            r_status    <= 2'd0;
            r_irq       <= 1'b0;
        end else begin
            if (w_accept) begin
                r_len    <= frame_len;
                r_count  <= (frame_count == 8'd0) ? 8'd1 : frame_count;
                r_guard  <= guard_interval;
                r_sent   <= 8'd0;
                r_status <= 2'd0;
            end
            if (w_finish) r_status <= w_status_next;
            if (w_inc_sent) r_sent <= w_sent_inc;

            // A new completion event wins over a same-cycle acknowledge.
            if (w_finish)     r_irq <= 1'b1;
            else if (irq_ack) r_irq <= 1'b0;

            if (w_load_guard)     r_guard_cnt <= r_guard;
            else if (w_dec_guard) r_guard_cnt <= r_guard_cnt - 32'd1;

            if (w_clr_tmo)      r_tmo <= 8'd0;
            else if (w_inc_tmo) r_tmo <= r_tmo + 8'd1;
        end
    end

    assign start_tx    = w_start_tx;
    assign busy        = (r_state != S_IDLE);
    assign frames_sent = r_sent;
    assign status      = r_status;
    assign irq         = r_irq;

endmodule
`default_nettype wire
